// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and BMP header layout for the image receiver
package sobel_pkg;
  localparam int HDR_BYTES = 54;
  localparam int PIX_W = 8;
  localparam logic [5:0] OFS_SIG = 6'd0;
  localparam logic [5:0] OFS_SIZE = 6'd2;
  localparam logic [5:0] OFS_OFFSET = 6'd10;
  localparam logic [5:0] OFS_WIDTH = 6'd18;
  localparam logic [5:0] OFS_HEIGHT = 6'd22;
  localparam logic [5:0] OFS_BPP = 6'd28;
  localparam logic [15:0] BPP_24 = 16'd24;
  localparam logic [15:0] SIG_BM = 16'h4D42;
  typedef enum logic [2:0] {IDLE, HDR, FILL, FULL, DONE} rcv_state_t;
  function automatic logic in_field(input logic [5:0] cnt, input logic [5:0] ofs, input logic [5:0] len);
    return cnt >= ofs && cnt < ofs + len;
  endfunction
endpackage

// File: rtl/image_receiver_rgb_to_gray.sv
// rgb_to_gray: combinational BGR to 8-bit luminance, (B + 2G + R) / 4
module rgb_to_gray import sobel_pkg::*; (
  input  logic [7:0]       b,
  input  logic [7:0]       g,
  input  logic [7:0]       r,
  output logic [PIX_W-1:0] gray
);
  logic [9:0] sum;
  assign sum = {2'b0, b} + {1'b0, g, 1'b0} + {2'b0, r};
  assign gray = sum[9:2];
endmodule

// File: rtl/image_receiver.sv
// image_receiver: BMP header parser and grayscale 3x3 window filler for the SED
module image_receiver import sobel_pkg::*; (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        read_header,
  input  logic        read_buffer,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        shift_window,
  output logic [31:0] img_size,
  output logic [15:0] img_width,
  output logic [15:0] img_height,
  output logic [31:0] pix_offset,
  output logic        header_valid,
  output logic        header_error,
  output logic [71:0] window,
  output logic        buffer_full,
  output logic        new_col,
  output logic        eof,
  output logic        overflow
);
  rcv_state_t state, nxt;
  logic [5:0] hdr_cnt;
  logic [15:0] sig, bpp;
  logic [31:0] img_area, pix_cnt;
  logic [3:0] fill_cnt;
  logic [1:0] byte_sel;
  logic [7:0] b_q, g_q;
  logic [PIX_W-1:0] gray;
  logic [8:0][PIX_W-1:0] win;
  logic start_hdr, acc_hdr, last_hdr, acc_pix, pix_done, hdr_bad;
  assign start_hdr = (state == IDLE || state == DONE) && read_header;
  assign acc_hdr = state == HDR && rx_valid;
  assign last_hdr = acc_hdr && hdr_cnt == 6'(HDR_BYTES - 1);
  assign acc_pix = state == FILL && read_buffer && rx_valid;
  assign pix_done = acc_pix && byte_sel == 2'd2;
  assign hdr_bad = sig != SIG_BM || bpp != BPP_24;
  assign window = win;
  rgb_to_gray u_gray (.b(b_q), .g(g_q), .r(rx_data), .gray(gray));
  // state register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  // next state; header request wins over pixel fill
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = read_header ? HDR : (read_buffer && header_valid) ? FILL : IDLE;
      HDR: nxt = last_hdr ? IDLE : HDR;
      FILL: nxt = eof ? DONE : (pix_done && fill_cnt == 4'd8) ? FULL : FILL;
      FULL: nxt = !shift_window ? FULL : eof ? DONE : FILL;
      DONE: nxt = read_header ? HDR : DONE;
      default: nxt = IDLE;
    endcase
  end
  // state-decoded controller flags
  always_comb begin
    buffer_full = state == FULL;
    new_col = state == FILL && !eof;
  end
  // header capture: little-endian fields shift in from the top byte lane
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      hdr_cnt <= '0;
      sig <= '0;
      bpp <= '0;
      img_size <= '0;
      pix_offset <= '0;
      img_width <= '0;
      img_height <= '0;
      img_area <= '0;
      header_valid <= 1'b0;
      header_error <= 1'b0;
    end else begin
      if (start_hdr) begin
        hdr_cnt <= '0;
        header_valid <= 1'b0;
        header_error <= 1'b0;
      end
      if (acc_hdr) begin
        hdr_cnt <= hdr_cnt + 6'd1;
        if (in_field(hdr_cnt, OFS_SIG, 6'd2)) sig <= {rx_data, sig[15:8]};
        if (in_field(hdr_cnt, OFS_SIZE, 6'd4)) img_size <= {rx_data, img_size[31:8]};
        if (in_field(hdr_cnt, OFS_OFFSET, 6'd4)) pix_offset <= {rx_data, pix_offset[31:8]};
        if (in_field(hdr_cnt, OFS_WIDTH, 6'd2)) img_width <= {rx_data, img_width[15:8]};
        if (in_field(hdr_cnt, OFS_HEIGHT, 6'd2)) img_height <= {rx_data, img_height[15:8]};
        if (in_field(hdr_cnt, OFS_BPP, 6'd2)) bpp <= {rx_data, bpp[15:8]};
      end
      if (last_hdr) begin
        header_error <= hdr_bad;
        header_valid <= !hdr_bad;
        img_area <= 32'(img_width) * 32'(img_height);
      end
    end
  // pixel assembly, window fill/shift and sticky status
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      pix_cnt <= '0;
      fill_cnt <= '0;
      byte_sel <= '0;
      b_q <= '0;
      g_q <= '0;
      win <= '0;
      eof <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start_hdr) begin
        eof <= 1'b0;
        pix_cnt <= '0;
        fill_cnt <= '0;
        byte_sel <= '0;
      end
      if (acc_pix) begin
        byte_sel <= pix_done ? 2'd0 : byte_sel + 2'd1;
        if (byte_sel == 2'd0) b_q <= rx_data;
        if (byte_sel == 2'd1) g_q <= rx_data;
      end
      if (pix_done) begin
        win[fill_cnt] <= gray;
        fill_cnt <= fill_cnt + 4'd1;
        pix_cnt <= pix_cnt + 32'd1;
      end
      if (state == FULL && shift_window) begin
        win <= {win[8:6], win[8:3]};
        fill_cnt <= 4'd6;
      end
      if (state == FULL && rx_valid) overflow <= 1'b1;
      if ((state == FILL || state == FULL) && pix_cnt == img_area) eof <= 1'b1;
    end
endmodule

// File: tb/tb_image_receiver.sv
// tb_image_receiver: vector table, hand sequences and random images against a pixel-stream model
module tb_image_receiver;
  logic clk = 0, n_rst = 0, read_header = 0, read_buffer = 0, rx_valid = 0, shift_window = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] img_size, pix_offset;
  logic [15:0] img_width, img_height;
  logic header_valid, header_error, buffer_full, new_col, eof, overflow;
  logic [71:0] window, w0;
  int n_cmp = 0, n_err = 0;
  typedef struct {logic [7:0] b, g, r, gray; logic full;} pix_vec_t;
  pix_vec_t tbl[9];
  image_receiver dut (.clk(clk), .n_rst(n_rst), .read_header(read_header), .read_buffer(read_buffer),
    .rx_data(rx_data), .rx_valid(rx_valid), .shift_window(shift_window), .img_size(img_size),
    .img_width(img_width), .img_height(img_height), .pix_offset(pix_offset), .header_valid(header_valid),
    .header_error(header_error), .window(window), .buffer_full(buffer_full), .new_col(new_col),
    .eof(eof), .overflow(overflow));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] d);
    rx_data = d;
    rx_valid = 1;
    tick();
    rx_valid = 0;
  endtask
  task automatic send_pixel(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
    send_byte(b);
    send_byte(g);
    send_byte(r);
  endtask
  task automatic header_bytes(input logic [7:0] s0, input logic [7:0] s1, input logic [31:0] size,
                              input logic [15:0] w, input logic [15:0] hgt, input logic [15:0] bpp, input int n);
    logic [7:0] hb[54];
    for (int i = 0; i < 54; i++) hb[i] = 8'($urandom);
    hb[0] = s0;
    hb[1] = s1;
    {hb[5], hb[4], hb[3], hb[2]} = size;
    {hb[13], hb[12], hb[11], hb[10]} = 32'd54;
    {hb[19], hb[18]} = w;
    {hb[23], hb[22]} = hgt;
    {hb[29], hb[28]} = bpp;
    read_buffer = 0;
    read_header = 1;
    tick();
    read_header = 0;
    for (int i = 0; i < n; i++) send_byte(hb[i]);
  endtask
  task automatic send_header(input logic [7:0] s0, input logic [7:0] s1, input logic [31:0] size,
                             input logic [15:0] w, input logic [15:0] hgt);
    header_bytes(s0, s1, size, w, hgt, 16'd24, 54);
  endtask
  task automatic reset_off();
    tick();
    n_rst = 1;
    tick();
  endtask
  function automatic logic [7:0] gray_of(input int b, input int g, input int r);
    return 8'((b + 2 * g + r) / 4);
  endfunction
  initial begin
    tbl[0] = '{8'h10, 8'h20, 8'h30, 8'h20, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 8'h3F, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 8'h00, 8'h7F, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 8'hFF, 8'h3F, 1'b0};
    tbl[6] = '{8'h01, 8'h01, 8'h01, 8'h01, 1'b0};
    tbl[7] = '{8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[8] = '{8'h80, 8'h40, 8'h20, 8'h48, 1'b1};
    #12;
    check("rst_size", img_size, 0);
    check("rst_hv", header_valid, 0);
    check("rst_full", buffer_full, 0);
    check("rst_newcol", new_col, 0);
    check("rst_eof", eof, 0);
    check("rst_win", window, 0);
    reset_off();
    send_header("P", "N", 32'hF6, 16'd4, 16'd4);
    check("pn_err", header_error, 1);
    check("pn_hv", header_valid, 0);
    header_bytes("B", "M", 32'hF6, 16'd4, 16'd4, 16'd24, 20);
    n_rst = 0;
    #2;
    check("midrst_size", img_size, 0);
    check("midrst_ofs", pix_offset, 0);
    check("midrst_err", header_error, 0);
    check("midrst_hv", header_valid, 0);
    reset_off();
    send_header("B", "M", 32'h000000F6, 16'd4, 16'd4);
    check("hdr_hv", header_valid, 1);
    check("hdr_err", header_error, 0);
    check("hdr_size", img_size, 246);
    check("hdr_w", img_width, 4);
    check("hdr_h", img_height, 4);
    check("hdr_ofs", pix_offset, 54);
    read_buffer = 1;
    tick();
    check("fill_newcol", new_col, 1);
    for (int i = 0; i < 9; i++) begin
      send_pixel(tbl[i].b, tbl[i].g, tbl[i].r);
      check($sformatf("tbl_gray%0d", i), window[8*i +: 8], tbl[i].gray);
      check($sformatf("tbl_full%0d", i), buffer_full, tbl[i].full);
    end
    check("full_newcol", new_col, 0);
    w0 = window;
    send_byte(8'hAA);
    check("ovf_flag", overflow, 1);
    check("ovf_win", window, w0);
    check("ovf_full", buffer_full, 1);
    shift_window = 1;
    tick();
    shift_window = 0;
    check("shift_win", window[47:0], w0[71:24]);
    check("shift_full", buffer_full, 0);
    check("shift_newcol", new_col, 1);
    for (int i = 0; i < 3; i++) send_pixel(8'h10, 8'h20, 8'h30);
    check("refill_full", buffer_full, 1);
    check("refill_win", window[71:48], 24'h202020);
    check("refill_eof", eof, 0);
    n_rst = 0;
    #2;
    check("rst2_win", window, 0);
    check("rst2_ovf", overflow, 0);
    check("rst2_full", buffer_full, 0);
    reset_off();
    send_header("B", "M", 32'd81, 16'd3, 16'd3);
    check("h33_hv", header_valid, 1);
    read_buffer = 1;
    tick();
    for (int i = 0; i < 9; i++) send_pixel(8'h10, 8'h20, 8'h30);
    check("e33_win", window, {9{8'h20}});
    check("e33_full", buffer_full, 1);
    check("e33_eof0", eof, 0);
    tick();
    check("e33_eof1", eof, 1);
    shift_window = 1;
    tick();
    shift_window = 0;
    check("e33_eof_hold", eof, 1);
    check("e33_full_off", buffer_full, 0);
    check("e33_newcol", new_col, 0);
    w0 = window;
    send_byte(8'h55);
    check("done_ign_win", window, w0);
    check("done_ign_ovf", overflow, 0);
    send_header("B", "M", 32'd54, 16'd0, 16'd0);
    check("z_hv", header_valid, 1);
    check("z_eof_clr", eof, 0);
    read_buffer = 1;
    tick();
    repeat (2) tick();
    check("z_eof", eof, 1);
    check("z_newcol", new_col, 0);
    for (int it = 0; it < 6; it++) begin
      logic [7:0] gq[$];
      logic [7:0] px[3];
      logic [71:0] exp;
      int w, hgt, area, p, k, gap;
      gq = {};
      w = $urandom_range(1, 5);
      hgt = $urandom_range(1, 4);
      area = w * hgt;
      p = 0;
      k = 0;
      send_header("B", "M", $urandom, 16'(w), 16'(hgt));
      check("rnd_hv", header_valid, 1);
      check("rnd_w", img_width, w);
      check("rnd_h", img_height, hgt);
      read_buffer = 1;
      tick();
      while (p < area) begin
        for (int j = 0; j < 3; j++) px[j] = 8'($urandom);
        for (int j = 0; j < 3; j++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            read_buffer = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            rx_valid = !read_buffer;
            tick();
            rx_valid = 0;
          end
          read_buffer = 1;
          send_byte(px[j]);
        end
        gq.push_back(gray_of(px[0], px[1], px[2]));
        p++;
        if (p - 3 * k == 9) begin
          for (int i = 0; i < 9; i++) exp[8*i +: 8] = gq[3*k + i];
          check("rnd_full", buffer_full, 1);
          check("rnd_win", window, exp);
          shift_window = 1;
          tick();
          shift_window = 0;
          k++;
        end else begin
          check("rnd_notfull", buffer_full, 0);
          if (p < area) check("rnd_newcol", new_col, 1);
        end
      end
      repeat (3) tick();
      check("rnd_eof", eof, 1);
      check("rnd_end_full", buffer_full, 0);
      check("rnd_end_newcol", new_col, 0);
    end
    check("rnd_ovf", overflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
Byte-stream front end between the SD interface and the Sobel edge detector. When the FSM controller asserts read_header, it parses the 54-byte BMP header and publishes image geometry, including img_size back to the controller. When the controller asserts read_buffer, it assembles 24-bit BGR pixels, converts each to 8-bit grayscale, and fills a 3x3 column-major window for the SED. It generates buffer_full, new_col and eof for the controller.

Parameters:
HDR_BYTES, 54, header length in bytes.
PIX_W, 8, grayscale pixel width.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
read_header  in  1  header-parse enable from controller
read_buffer  in  1  pixel-fill enable from controller
rx_data  in  8  byte from SD interface
rx_valid  in  1  rx_data valid strobe, one byte per cycle max
shift_window  in  1  one-cycle pulse; SED result consumed, advance window one column
img_size  out  32  BMP file size in bytes (header bytes 2..5, little-endian)
img_width  out  16  header bytes 18..19
img_height  out  16  header bytes 22..23
pix_offset  out  32  header bytes 10..13
header_valid  out  1  header fully parsed and legal
header_error  out  1  sticky; signature not "BM" or bpp (bytes 28..29) not 24
window  out  72  9 gray pixels; [8*i +: 8] is index i = col*3 + row, col 0 is oldest
buffer_full  out  1  all 9 window entries valid
new_col  out  1  window not full and more pixels are required
eof  out  1  sticky; pixel count equals img_width*img_height
overflow  out  1  sticky; byte received while buffer_full

Behaviour:
- Reset: all outputs are 0. The state is IDLE and all counters are 0. Reset is legal mid-header or mid-pixel and aborts all progress.
- States:
  - IDLE:
    - read_header goes to HDR and clears hdr_cnt, header_valid, header_error, eof, pix_cnt and fill_cnt.
    - read_buffer with header_valid goes to FILL.
  - HDR:
    - Each rx_valid stores the byte at offset hdr_cnt into the matching field (little-endian), then increments hdr_cnt.
    - When byte 53 is accepted, go to IDLE the next cycle. header_valid = !header_error, registered.
  - FILL:
    - Bytes are accepted only while read_buffer is high. byte_sel cycles B, G, R.
    - On R: gray = (B + 2*G + R) >> 2, computed with a 10-bit sum and taking bits [9:2].
    - gray is written to window index fill_cnt. fill_cnt and pix_cnt both increment.
    - When fill_cnt reaches 9, go to FULL.
    - If read_buffer drops, stay in FILL and hold partial byte_sel.
  - FULL:
    - buffer_full=1.
    - On shift_window: entries 3..8 move to 0..5, fill_cnt=6, then go to FILL, or to DONE if eof.
    - rx_valid in FULL sets overflow and the byte is discarded.
  - DONE: eof=1 and the block holds. read_header restarts via HDR.
- new_col = (state==FILL) && !eof. This is registered, so it is valid on the cycle after the triggering byte.
- eof is set in the cycle after pix_cnt (32-bit) == img_width*img_height (16x16->32 product, registered once at header completion). A 0x0 image sets eof immediately on entering FILL.
- Priority when read_header and read_buffer are both high: header wins.
- rx_valid outside HDR/FILL is ignored.
- shift_window outside FULL is ignored.
- Latency: gray pixel lands in window 1 cycle after the R byte. buffer_full rises 1 cycle after the 9th pixel.

Decomposition:
- Shared package sobel_pkg:
  - state enum rcv_state_t
  - constant HDR_BYTES
  - field offset constants: OFS_SIG=0, OFS_SIZE=2, OFS_OFFSET=10, OFS_WIDTH=18, OFS_HEIGHT=22, OFS_BPP=28
  - constant BPP_24
- One sub-module, rgb_to_gray: combinational BGR->8-bit luminance, reusable by the writer path.

Test Plan:
- Valid header, "BM", size 0x000000F6, width 4, height 4, bpp 24 -> after 54 bytes: header_valid=1, img_size=246, img_width=4, img_height=4, header_error=0.
- Header with bytes 0..1 = "PN" -> header_error=1 and header_valid=0 after byte 53.
- 9 pixels B=0x10, G=0x20, R=0x30 -> each window entry = 0x20. buffer_full=1 one cycle after the 27th byte. new_col=0.
- shift_window in FULL -> entries 0..5 equal the old 3..8 and buffer_full=0. new_col=1. After 3 more pixels buffer_full=1 again.
- 3x3 image: 9th pixel -> eof=1 and it stays high through shift_window. State reaches DONE.
- rx_valid during FULL -> overflow=1 and the window is unchanged. Asserting n_rst low mid-header clears all outputs, and a later fresh header parses correctly.
